// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - request, response and ROM signals of the instruction-memory arbiter
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req0;
    logic              i_req1;
    logic [ADDR_W-1:0] i_addr0;
    logic [ADDR_W-1:0] i_addr1;
    logic              o_gnt0;
    logic              o_gnt1;
    logic              o_rvalid0;
    logic              o_rvalid1;
    logic [DATA_W-1:0] o_rdata;
    logic              o_rerr;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_ready;
    logic              i_mem_valid;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_req0, i_req1, i_addr0, i_addr1, i_mem_valid, i_mem_rdata,
        output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata, o_rerr,
        output o_mem_addr, o_mem_ready
    );

    modport master (
        output i_req0, i_req1, i_addr0, i_addr1, i_mem_valid, i_mem_rdata,
        input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata, o_rerr,
        input  o_mem_addr, o_mem_ready
    );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-port round-robin arbiter in front of an instruction ROM
module imem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic              sel;
    logic              prio1;
    logic [CNT_W-1:0]  cnt;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic              misaligned;

    // Under contention the pointer picks the port that lost last time.
    always_comb begin
        win = 1'b0;
        if (bus.i_req0 && bus.i_req1) begin
            win = prio1;
        end else begin
            win = bus.i_req1;
        end
        win_addr   = win ? bus.i_addr1 : bus.i_addr0;
        misaligned = (win_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            sel             <= 1'b0;
            prio1           <= 1'b0;
            cnt             <= '0;
            bus.o_gnt0      <= 1'b0;
            bus.o_gnt1      <= 1'b0;
            bus.o_rvalid0   <= 1'b0;
            bus.o_rvalid1   <= 1'b0;
            bus.o_rdata     <= '0;
            bus.o_rerr      <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_ready <= 1'b0;
        end else begin
            bus.o_gnt0    <= 1'b0;
            bus.o_gnt1    <= 1'b0;
            bus.o_rvalid0 <= 1'b0;
            bus.o_rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req0 || bus.i_req1) begin
                        bus.o_gnt0     <= ~win;
                        bus.o_gnt1     <= win;
                        sel            <= win;
                        prio1          <= ~win;
                        bus.o_mem_addr <= win_addr;
                        cnt            <= '0;
                        // Misaligned fetches never reach the ROM.
                        if (misaligned) begin
                            bus.o_mem_ready <= 1'b0;
                            bus.o_rerr      <= 1'b1;
                            bus.o_rdata     <= '0;
                            state           <= RESP;
                        end else begin
                            bus.o_mem_ready <= 1'b1;
                            state           <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.i_mem_valid) begin
                        bus.o_rdata     <= bus.i_mem_rdata;
                        bus.o_rerr      <= 1'b0;
                        bus.o_mem_ready <= 1'b0;
                        state           <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.o_rdata     <= '0;
                        bus.o_rerr      <= 1'b1;
                        bus.o_mem_ready <= 1'b0;
                        state           <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    bus.o_rvalid0   <= ~sel;
                    bus.o_rvalid1   <= sel;
                    bus.o_mem_ready <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    bus.o_mem_ready <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter
module tb_imem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          lat;
    } resp_t;

    resp_t exp_q[$];
    int    gnt_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ready_cnt = 0;
    int    gnt_cyc = 0;
    bit    rom_en = 1'b1;
    bit    late_valid = 1'b0;
    int    mon_port;
    resp_t mon_e;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_data(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h0050_0093;
            32'h0000_2000: return 32'h00A0_0113;
            default:       return 32'hDEAD_0000 ^ a;
        endcase
    endfunction

    // ROM answers in the first cycle it sees the issue strobe.
    initial forever begin
        @(negedge clk);
        #1;
        bus.i_mem_valid = late_valid || (rom_en && bus.o_mem_ready);
        bus.i_mem_rdata = rom_data(bus.o_mem_addr);
    end

    initial forever begin
        @(negedge clk);
        if (bus.o_mem_ready) ready_cnt++;
        if (bus.o_gnt0 && bus.o_gnt1) chk("gnt_exclusive", 2'b11, 2'b01);
        if (bus.o_rvalid0 && bus.o_rvalid1) chk("rvalid_exclusive", 2'b11, 2'b01);
        if (bus.o_gnt0 || bus.o_gnt1) begin
            gnt_cyc = cyc;
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", {bus.o_gnt1, bus.o_gnt0}, 2'b00);
            end else begin
                mon_port = gnt_q.pop_front();
                chk("gnt_port", bus.o_gnt1, mon_port);
            end
        end
        if (bus.o_rvalid0 || bus.o_rvalid1) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", {bus.o_rvalid1, bus.o_rvalid0}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rvalid_port", bus.o_rvalid1, mon_e.port);
                chk("rdata", bus.o_rdata, mon_e.data);
                chk("rerr", bus.o_rerr, mon_e.err);
                chk("latency", cyc - gnt_cyc, mon_e.lat);
            end
        end
    end

    task automatic wait_gnt(input string name, output int port, output int at);
        port = -1;
        at   = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.o_gnt0 || bus.o_gnt1) begin
                port = bus.o_gnt1 ? 1 : 0;
                at   = cyc;
                break;
            end
        end
        if (port < 0) chk({name, "_gnt_timeout"}, 1, 0);
    endtask

    task automatic wait_rvalid(input string name, output int at);
        at = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.o_rvalid0 || bus.o_rvalid1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk({name, "_rvalid_timeout"}, 1, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_gnt"},    {bus.o_gnt1, bus.o_gnt0}, 2'b00);
        chk({name, "_rvalid"}, {bus.o_rvalid1, bus.o_rvalid0}, 2'b00);
        chk({name, "_rerr"},   bus.o_rerr, 1'b0);
        chk({name, "_ready"},  bus.o_mem_ready, 1'b0);
        chk({name, "_addr"},   bus.o_mem_addr, 32'h0);
        chk({name, "_rdata"},  bus.o_rdata, 32'h0);
    endtask

    initial begin
        int port;
        int gc;
        int prev;
        int rc;
        int r0;
        rst         = 1'b1;
        bus.i_req0  = 1'b0;
        bus.i_req1  = 1'b0;
        bus.i_addr0 = 32'h0;
        bus.i_addr1 = 32'h0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Contention: both held, grants alternate 0,1,0,1 three cycles apart.
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        exp_q.push_back('{0, 32'h0050_0093, 1'b0, 2});
        exp_q.push_back('{1, 32'h00A0_0113, 1'b0, 2});
        exp_q.push_back('{0, 32'h0050_0093, 1'b0, 2});
        exp_q.push_back('{1, 32'h00A0_0113, 1'b0, 2});
        bus.i_addr0 = 32'h1000;
        bus.i_addr1 = 32'h2000;
        bus.i_req0  = 1'b1;
        bus.i_req1  = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("contention", port, gc);
            if (k > 0) chk("contention_spacing", gc - prev, 3);
            prev = gc;
        end
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        repeat (4) @(negedge clk);

        // Single fetch from port 0.
        gnt_q.push_back(0);
        exp_q.push_back('{0, 32'h0050_0093, 1'b0, 2});
        r0 = ready_cnt;
        bus.i_req0 = 1'b1;
        wait_gnt("single", port, gc);
        bus.i_req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("single_ready_cycles", ready_cnt - r0, 1);

        // Misaligned request on port 1 never reaches the ROM.
        gnt_q.push_back(1);
        exp_q.push_back('{1, 32'h0, 1'b1, 1});
        r0 = ready_cnt;
        bus.i_addr1 = 32'h1002;
        bus.i_req1  = 1'b1;
        wait_gnt("misaligned", port, gc);
        bus.i_req1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("misaligned_ready_cycles", ready_cnt - r0, 0);

        // Timeout: ROM silent, then a new request right after the error response.
        rom_en = 1'b0;
        gnt_q.push_back(0);
        exp_q.push_back('{0, 32'h0, 1'b1, 9});
        r0 = ready_cnt;
        bus.i_req0 = 1'b1;
        wait_gnt("timeout", port, gc);
        bus.i_req0 = 1'b0;
        wait_rvalid("timeout", rc);
        chk("timeout_ready_cycles", ready_cnt - r0, 8);
        rom_en = 1'b1;
        gnt_q.push_back(1);
        exp_q.push_back('{1, 32'h00A0_0113, 1'b0, 2});
        bus.i_addr1 = 32'h2000;
        bus.i_req1  = 1'b1;
        wait_gnt("after_timeout", port, gc);
        bus.i_req1 = 1'b0;
        chk("idle_after_resp", gc - rc, 1);
        repeat (4) @(negedge clk);

        // Port 1 request withdrawn while the FSM is busy.
        gnt_q.push_back(0);
        exp_q.push_back('{0, 32'h0050_0093, 1'b0, 2});
        bus.i_req0 = 1'b1;
        wait_gnt("withdrawn", port, gc);
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b1;
        @(negedge clk);
        bus.i_req1 = 1'b0;
        repeat (6) @(negedge clk);

        // Reset one cycle after the grant aborts the fetch.
        rom_en = 1'b0;
        gnt_q.push_back(0);
        bus.i_req0 = 1'b1;
        wait_gnt("reset_wait", port, gc);
        bus.i_req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_wait");
        late_valid = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        late_valid = 1'b0;
        rom_en = 1'b1;
        @(negedge clk);
        gnt_q.push_back(0);
        exp_q.push_back('{0, 32'h0050_0093, 1'b0, 2});
        bus.i_req0 = 1'b1;
        bus.i_req1 = 1'b1;
        wait_gnt("post_reset", port, gc);
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        chk("post_reset_port", port, 0);
        repeat (6) @(negedge clk);

        chk("gnt_q_empty", gnt_q.size(), 0);
        chk("resp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, read-data width.
REQ-003 SHALL have parameter TIMEOUT, default 8, number of WAIT cycles allowed without memory valid before an error response.
REQ-004 clk  input  1  the single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_req0 / i_req1  input  1  read request from port 0 (fetch) / port 1 (loader/debug), level-held until granted.
REQ-007 i_addr0 / i_addr1  input  ADDR_W  byte address of each request.
REQ-008 o_gnt0 / o_gnt1  output  1  one-cycle grant pulse; the request is accepted in that cycle.
REQ-009 o_rvalid0 / o_rvalid1  output  1  one-cycle response pulse.
REQ-010 o_rdata  output  DATA_W  response data, shared by both ports, qualified by o_rvalidN.
REQ-011 o_rerr  output  1  response is an error, qualified by o_rvalidN.
REQ-012 o_mem_addr  output  ADDR_W  address to the instruction ROM.
REQ-013 o_mem_ready  output  1  issue strobe to the ROM.
REQ-014 i_mem_valid  input  1  ROM valid.
REQ-015 i_mem_rdata  input  DATA_W  ROM read data.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE with any request asserted, SHALL pulse exactly one grant and load o_mem_addr from the granted port's address.
- Same cycle: assert o_mem_ready.
- Next state: WAIT.
REQ-018 Arbitration SHALL be round-robin.
- Single requester: it wins.
- Both requesting: the port not granted most recently wins.
- Priority pointer resets to favour port 0.
REQ-019 Misaligned address (addr[1:0] != 0) SHALL be granted without asserting o_mem_ready, and SHALL go directly to RESP with o_rerr=1 and o_rdata=0.
REQ-020 In WAIT, SHALL hold o_mem_addr and o_mem_ready=1 and count cycles.
- First cycle i_mem_valid=1: capture i_mem_rdata into o_rdata, o_rerr=0, go to RESP.
REQ-021 If TIMEOUT WAIT cycles pass without i_mem_valid, SHALL go to RESP with o_rerr=1 and o_rdata=0.
- The counter is $clog2(TIMEOUT+1) bits wide, saturating.
- The counter clears on every entry to WAIT.
REQ-022 In RESP, SHALL pulse o_rvalidN for the granted port only, deassert o_mem_ready, then return to IDLE.
REQ-023 Latency SHALL be fixed for a ROM answering in the first WAIT cycle:
- Grant in cycle N.
- Data captured in cycle N+1.
- o_rvalid in cycle N+2.
- Next grant earliest in cycle N+3.
REQ-024 SHALL ignore requests and address changes while in WAIT or RESP; the winner is latched at grant.
REQ-025 o_rdata and o_rerr SHALL hold their last values outside RESP.
REQ-026 At most one outstanding transaction SHALL exist.
- o_gnt0 and o_gnt1 are never both high.
- o_rvalid0 and o_rvalid1 are never both high.
REQ-027 A requester deasserting i_reqN before grant SHALL simply be ignored; there is no partial transaction.

Reset
REQ-028 While rst=1 at a clock edge, SHALL set:
- state IDLE;
- all grants, rvalids, o_rerr and o_mem_ready to 0;
- o_mem_addr and o_rdata to 0;
- timeout counter 0;
- round-robin pointer favouring port 0.
REQ-029 Reset asserted mid-transaction (WAIT or RESP) SHALL abort it with no o_rvalid pulse; any late i_mem_valid after reset SHALL be ignored.

Verification
REQ-030 Single fetch: i_req0=1, i_addr0=0x1000, ROM returns 0x00500093 one cycle after ready -> o_gnt0 in cycle N, o_rvalid0 with o_rdata=0x00500093 and o_rerr=0 in cycle N+2.
REQ-031 Contention: both requests held continuously, addresses 0x1000 and 0x2000 -> grants alternate 0,1,0,1 every 3 cycles; each o_rvalid carries that port's data.
REQ-032 Misaligned: i_req1=1, i_addr1=0x1002 -> o_gnt1; o_mem_ready never asserted; o_rvalid1 with o_rerr=1 and o_rdata=0 one cycle after the grant.
REQ-033 Timeout: TIMEOUT=8, i_mem_valid held 0 -> o_mem_ready high for 8 cycles, then o_rvalid0 with o_rerr=1; FSM back in IDLE next cycle.
REQ-034 Reset in WAIT: rst=1 one cycle after o_gnt0 -> no o_rvalid0; all outputs 0; first request after reset with both ports requesting grants port 0.
REQ-035 Withdrawn request: i_req1 pulsed for one cycle while FSM in WAIT -> no o_gnt1 ever issued for it.
